// File: rtl/lsu_mem_port_pkg.sv
// Shared definitions for the load/store memory port: access-size encodings,
// the port FSM state type and the alignment helpers used at request accept.
package lsu_pkg;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } lsu_state_e;

   // True for a reserved size or an address not aligned to the access size.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
      logic bad;
      case (size)
         SZ_WORD: bad = (addr != 2'b00);
         SZ_HALF: bad = addr[0];
         SZ_BYTE: bad = 1'b0;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Clears the low address bits that the access size does not allow.
   function automatic logic [1:0] force_align(input logic [1:0] size, input logic [1:0] addr);
      logic [1:0] a;
      case (size)
         SZ_HALF: a = {addr[1], 1'b0};
         SZ_BYTE: a = addr;
         default: a = 2'b00;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Bundle of the core-side request/response handshakes and the memory-side
// access bus. The port itself uses the slave view; the core/memory side (or a
// bench) uses the master view.
interface lsu_mem_port_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   logic        mem_en;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready,
      output rsp_valid, rsp_rdata, rsp_err,
      input  rsp_ready,
      output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready,
      input  rsp_valid, rsp_rdata, rsp_err,
      output rsp_ready,
      input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: byte enables and lane-replicated store
// data for the memory, and lane extraction plus sign/zero extension of the
// memory read word for loads.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   input  logic        is_unsigned,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Select the addressed lane and build enables / replicated data per size.
   always_comb begin
      be        = 4'b1111;
      wdata_rep = wdata;
      rdata_ext = rdata;
      case (addr_lo)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (size)
         SZ_BYTE: begin
            be        = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
            rdata_ext = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
         end
         SZ_HALF: begin
            be        = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata[15:0]}};
            rdata_ext = {{16{~is_unsigned & half_sel[15]}}, half_sel};
         end
         default: begin
            be        = 4'b1111;
            wdata_rep = wdata;
            rdata_ext = rdata;
         end
      endcase
   end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store port between the RV32I datapath and a synchronous data memory.
// One request at a time: accept, issue a single word access with byte enables,
// wait MEM_LAT cycles for load data, then hold the response until taken.
// Build option: define LSU_MISALIGN_TRAP_EN to report misaligned or
// reserved-size requests as errors with no memory access; otherwise such
// requests are force-aligned (reserved size acts as word) and rsp_err is 0.
module lsu_mem_port
   import lsu_pkg::*;
#(
   parameter int MEM_LAT = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   lsu_mem_port_if.slave bus
);

   localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

   lsu_state_e  state_q, state_d;
   logic [1:0]  cnt_q;

   logic        we_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        err_q;
   logic [31:0] rdata_q;

   logic        accept;
   logic        req_err;
   logic [1:0]  size_eff;
   logic [31:0] addr_eff;

   logic [3:0]  be;
   logic [31:0] wdata_rep;
   logic [31:0] rdata_ext;

   logic        in_issue;
   logic        in_resp;

   assign accept = bus.req_valid & (state_q == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
   assign req_err  = misaligned(bus.req_size, bus.req_addr[1:0]);
   assign size_eff = bus.req_size;
   assign addr_eff = bus.req_addr;
`else
   assign req_err  = 1'b0;
   assign size_eff = (bus.req_size == SZ_RSVD) ? SZ_WORD : bus.req_size;
   assign addr_eff = {bus.req_addr[31:2], force_align(size_eff, bus.req_addr[1:0])};
`endif

   lsu_lane_align u_align (
      .size        (size_q),
      .addr_lo     (addr_q[1:0]),
      .wdata       (wdata_q),
      .rdata       (bus.mem_rdata),
      .is_unsigned (uns_q),
      .be          (be),
      .wdata_rep   (wdata_rep),
      .rdata_ext   (rdata_ext)
   );

   // FSM state and latency counter; reset drops any in-flight request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         if (state_q == ISSUE) begin
            cnt_q <= LAT_M1;
         end else if ((state_q == WAIT) && (cnt_q != 2'd0)) begin
            cnt_q <= cnt_q - 2'd1;
         end
      end
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.req_valid) state_d = req_err ? RESP : ISSUE;
         ISSUE:   state_d = we_q ? RESP : WAIT;
         WAIT:    if (cnt_q == 2'd0) state_d = RESP;
         RESP:    if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request capture at accept and load-data capture on the last WAIT cycle.
   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= bus.req_we;
         size_q  <= size_eff;
         uns_q   <= bus.req_unsigned;
         addr_q  <= addr_eff;
         wdata_q <= bus.req_wdata;
         err_q   <= req_err;
         rdata_q <= 32'd0;
      end else if ((state_q == WAIT) && (cnt_q == 2'd0)) begin
         rdata_q <= rdata_ext;
      end
   end

   assign in_issue = (state_q == ISSUE);
   assign in_resp  = (state_q == RESP);

   assign bus.req_ready = rst_n & (state_q == IDLE);

   assign bus.mem_en    = in_issue;
   assign bus.mem_we    = in_issue & we_q;
   assign bus.mem_be    = in_issue ? be : 4'b0000;
   assign bus.mem_addr  = in_issue ? addr_q[31:2] : 30'd0;
   assign bus.mem_wdata = in_issue ? wdata_rep : 32'd0;

   assign bus.rsp_valid = in_resp;
   assign bus.rsp_err   = in_resp & err_q;
   assign bus.rsp_rdata = in_resp ? rdata_q : 32'd0;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: two instances (MEM_LAT 1 and 3) receive identical
// requests; each has its own memory model. Expected values come from a
// byte-addressed reference memory and the access rules.
module tb_lsu_mem_port;
   import lsu_pkg::*;

   localparam int LAT0 = 1;
   localparam int LAT1 = 3;

   logic clk;
   logic rst_n;
   logic load_init;
   int   total;
   int   bad;

   lsu_mem_port_if bus0 ();
   lsu_mem_port_if bus1 ();

   lsu_mem_port #(.MEM_LAT(LAT0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   lsu_mem_port #(.MEM_LAT(LAT1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic        o_en [2];
   logic        o_we [2];
   logic [3:0]  o_be [2];
   logic [29:0] o_addr [2];
   logic [31:0] o_wd [2];
   logic        o_rv [2];
   logic        o_err [2];
   logic [31:0] o_rd [2];
   logic        o_rr [2];
   logic        rsp_rdy [2];
   logic [31:0] mrd [2];

   assign o_en[0] = bus0.mem_en;     assign o_en[1] = bus1.mem_en;
   assign o_we[0] = bus0.mem_we;     assign o_we[1] = bus1.mem_we;
   assign o_be[0] = bus0.mem_be;     assign o_be[1] = bus1.mem_be;
   assign o_addr[0] = bus0.mem_addr; assign o_addr[1] = bus1.mem_addr;
   assign o_wd[0] = bus0.mem_wdata;  assign o_wd[1] = bus1.mem_wdata;
   assign o_rv[0] = bus0.rsp_valid;  assign o_rv[1] = bus1.rsp_valid;
   assign o_err[0] = bus0.rsp_err;   assign o_err[1] = bus1.rsp_err;
   assign o_rd[0] = bus0.rsp_rdata;  assign o_rd[1] = bus1.rsp_rdata;
   assign o_rr[0] = bus0.req_ready;  assign o_rr[1] = bus1.req_ready;
   assign bus0.rsp_ready = rsp_rdy[0];
   assign bus1.rsp_ready = rsp_rdy[1];
   assign bus0.mem_rdata = mrd[0];
   assign bus1.mem_rdata = mrd[1];

   function automatic logic [31:0] init_word(input int w);
      return 32'(w) * 32'h9E37_79B1 + 32'h0F1E_2D3C;
   endfunction

   // Memory devices: 128 words each, read data valid exactly MEM_LAT cycles
   // after the enable cycle, random junk at every other time.
   logic [31:0] dev [2][128];
   logic        pv [2][4];
   logic [31:0] pd [2][4];
   logic [31:0] junk;

   always @(posedge clk) begin
      junk <= $urandom;
      for (int k = 0; k < 2; k++) begin
         for (int s = 3; s > 0; s--) begin
            pv[k][s] <= pv[k][s-1];
            pd[k][s] <= pd[k][s-1];
         end
         pv[k][0] <= o_en[k] & ~o_we[k];
         pd[k][0] <= dev[k][o_addr[k][6:0]];
         if (load_init) begin
            for (int w = 0; w < 128; w++) dev[k][w] <= init_word(w);
         end else if (o_en[k] && o_we[k]) begin
            for (int b = 0; b < 4; b++)
               if (o_be[k][b]) dev[k][o_addr[k][6:0]][8*b +: 8] <= o_wd[k][8*b +: 8];
         end
      end
   end

   always_comb begin
      mrd[0] = pv[0][LAT0-1] ? pd[0][LAT0-1] : junk;
      mrd[1] = pv[1][LAT1-1] ? pd[1][LAT1-1] : junk;
   end

   logic [7:0] ref_mem [512];

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s dut%0d observed=0x%08h expected=0x%08h", tag, k, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
      bus0.req_valid = v; bus0.req_we = we; bus0.req_size = size; bus0.req_unsigned = uns;
      bus0.req_addr = addr; bus0.req_wdata = wd;
      bus1.req_valid = v; bus1.req_we = we; bus1.req_size = size; bus1.req_unsigned = uns;
      bus1.req_addr = addr; bus1.req_wdata = wd;
   endtask

   task automatic chk_quiet(input string tag, input logic rr);
      for (int k = 0; k < 2; k++) begin
         chk({tag, "_mem_en"}, k, 32'(o_en[k]), 32'd0);
         chk({tag, "_mem_we"}, k, 32'(o_we[k]), 32'd0);
         chk({tag, "_mem_be"}, k, 32'(o_be[k]), 32'd0);
         chk({tag, "_mem_addr"}, k, 32'(o_addr[k]), 32'd0);
         chk({tag, "_mem_wdata"}, k, o_wd[k], 32'd0);
         chk({tag, "_rsp_valid"}, k, 32'(o_rv[k]), 32'd0);
         chk({tag, "_rsp_err"}, k, 32'(o_err[k]), 32'd0);
         chk({tag, "_rsp_rdata"}, k, o_rd[k], 32'd0);
         chk({tag, "_req_ready"}, k, 32'(o_rr[k]), 32'(rr));
      end
   endtask

   // One request through both ports; rsp_ready is held low for 'stall'
   // cycles after rsp_valid first appears.
   task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd, input int stall);
      int n, a, eff;
      logic ill;
      logic [31:0] e_be, e_wd, e_rd;
      longint v;
      int lat [2];
      int first [2];
      int encnt [2];
      bit done [2];
      bit hs [2];
      a = int'(addr[8:0]);
      n = (size == SZ_HALF) ? 2 : (size == SZ_BYTE) ? 1 : 4;
`ifdef LSU_MISALIGN_TRAP_EN
      ill = (size == SZ_RSVD) || (a % n != 0);
      eff = a;
`else
      ill = 1'b0;
      eff = a - (a % n);
`endif
      e_be = 32'(((1 << n) - 1) << (eff % 4));
      e_wd = (n == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
             (n == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
      e_rd = 32'd0;
      if (!ill && !we) begin
         v = 0;
         for (int i = 0; i < n; i++) v += longint'(ref_mem[eff + i]) << (8 * i);
         if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
         e_rd = v[31:0];
      end
      if (!ill && we) begin
         for (int i = 0; i < n; i++) ref_mem[eff + i] = 8'(e_wd >> (8 * ((eff + i) % 4)));
      end
      lat[0] = ill ? 1 : we ? 2 : 2 + LAT0;
      lat[1] = ill ? 1 : we ? 2 : 2 + LAT1;
      for (int k = 0; k < 2; k++) begin
         first[k] = -1; encnt[k] = 0; done[k] = 1'b0; hs[k] = 1'b0;
         chk("req_ready_before", k, 32'(o_rr[k]), 32'd1);
      end
      drive(1'b1, we, size, uns, addr, wd);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
      for (int c = 1; c <= 40 && !(done[0] && done[1]); c++) begin
         for (int k = 0; k < 2; k++) begin
            if (!done[k]) begin
               if (o_en[k]) begin
                  encnt[k]++;
                  chk("mem_en_cycle", k, 32'(c), 32'd1);
                  chk("mem_we", k, 32'(o_we[k]), 32'(we));
                  chk("mem_be", k, 32'(o_be[k]), e_be);
                  chk("mem_addr", k, 32'(o_addr[k]), 32'(eff / 4));
                  chk("mem_wdata", k, o_wd[k], e_wd);
               end else begin
                  chk("mem_be_idle", k, 32'(o_be[k]), 32'd0);
               end
               chk("req_ready_busy", k, 32'(o_rr[k]), 32'd0);
               if (o_rv[k]) begin
                  if (first[k] < 0) begin
                     first[k] = c;
                     chk("rsp_latency", k, 32'(c), 32'(lat[k]));
                  end
                  chk("rsp_rdata", k, o_rd[k], e_rd);
                  chk("rsp_err", k, 32'(o_err[k]), 32'(ill));
                  if (c - first[k] >= stall) begin
                     rsp_rdy[k] = 1'b1;
                     hs[k] = 1'b1;
                  end
               end
            end
         end
         @(posedge clk); #1;
         for (int k = 0; k < 2; k++) begin
            if (hs[k] && !done[k]) begin
               rsp_rdy[k] = 1'b0;
               done[k] = 1'b1;
               chk("rsp_valid_after_hs", k, 32'(o_rv[k]), 32'd0);
               chk("req_ready_after_hs", k, 32'(o_rr[k]), 32'd1);
            end
         end
      end
      for (int k = 0; k < 2; k++) begin
         chk("completed", k, 32'(done[k]), 32'd1);
         chk("mem_en_count", k, 32'(encnt[k]), ill ? 32'd0 : 32'd1);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0;
      bad = 0;
      rst_n = 1'b0;
      load_init = 1'b1;
      rsp_rdy[0] = 1'b0;
      rsp_rdy[1] = 1'b0;
      drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
      for (int a = 0; a < 512; a++) ref_mem[a] = 8'(init_word(a / 4) >> (8 * (a % 4)));

      @(posedge clk); #1;
      chk_quiet("in_reset", 1'b0);
      @(posedge clk); #1;
      load_init = 1'b0;
      rst_n = 1'b1;
      #1;
      chk_quiet("after_reset", 1'b1);

      txn(1'b1, SZ_BYTE, 1'b0, 32'h103, 32'h0000_00AB, 0);
      txn(1'b1, SZ_WORD, 1'b0, 32'h100, 32'h1234_F678, 0);
      txn(1'b0, SZ_BYTE, 1'b0, 32'h101, 32'd0, 0);
      txn(1'b0, SZ_BYTE, 1'b1, 32'h101, 32'd0, 0);
      txn(1'b1, SZ_WORD, 1'b0, 32'h100, 32'h8001_7FFF, 0);
      txn(1'b0, SZ_HALF, 1'b0, 32'h102, 32'd0, 1);
      txn(1'b0, SZ_HALF, 1'b1, 32'h102, 32'd0, 0);
      txn(1'b0, SZ_WORD, 1'b0, 32'h006, 32'd0, 0);
      txn(1'b1, SZ_HALF, 1'b0, 32'h105, 32'hCAFE_BABE, 0);
      txn(1'b0, SZ_RSVD, 1'b1, 32'h10A, 32'd0, 2);
      txn(1'b0, SZ_WORD, 1'b0, 32'h104, 32'd0, 4);

      // Reset pulse while both ports are waiting on load data.
      drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h104, 32'd0);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk_quiet("mid_reset", 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         chk_quiet("post_reset_idle", 1'b1);
      end
      txn(1'b0, SZ_HALF, 1'b0, 32'h106, 32'd0, 0);

      for (int i = 0; i < 150; i++) begin
         txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 511)), $urandom, int'($urandom_range(0, 2)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
